// File: rtl/blackjack_pkg.sv
// Shared types and helpers for the blackjack game blocks.
package blackjack_pkg;

  typedef logic [3:0] rank_t;
  typedef logic [3:0] value_t;

  localparam rank_t  RANK_ACE       = 4'd1;
  localparam rank_t  RANK_KING      = 4'd13;
  localparam value_t FACE_VALUE     = 4'd10;
  localparam int     CARDS_PER_DECK = 52;

  typedef enum logic [1:0] {
    S_INIT,
    S_SHUFFLE,
    S_READY
  } dealer_state_t;

  function automatic value_t rank_to_value(input rank_t r);
    return (r > FACE_VALUE) ? FACE_VALUE : value_t'(r);
  endfunction

  // Smallest 2^k-1 covering i: every bit at or below i's MSB.
  function automatic logic [7:0] fy_mask(input logic [7:0] i);
    logic [7:0] m;
    m = 8'h0;
    m[7] = i[7];
    for (int k = 6; k >= 0; k--) begin
      m[k] = m[k+1] | i[k];
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with seed load; zero seed falls back to SEED.
module lfsr16 #(
  parameter logic [15:0] POLY = 16'hB400,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] nxt;

  always_comb begin
    nxt = state >> 1;
    if (state[0]) nxt = nxt ^ POLY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= SEED;
    else if (seed_load)
      state <= (seed == 16'h0) ? SEED : seed;
    else
      state <= nxt;
  end

endmodule

// File: rtl/card_dealer.sv
// Shoe of NUM_DECKS x 52 cards: Fisher-Yates shuffle, deal without replacement.
// Define CARD_DEALER_TEST_DECK_EN to skip the shuffle and deal in order.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int          NUM_DECKS        = 1,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  parameter int          RESHUFFLE_THRESH = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shuffle_req,
  input  logic        deal_req,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        deal_valid,
  output logic [3:0]  card_rank,
  output logic [3:0]  card_value,
  output logic [7:0]  cards_left,
  output logic        busy,
  output logic        reshuffle_due
);

  localparam int         DECK_SIZE = CARDS_PER_DECK * NUM_DECKS;
  localparam int         IW        = $clog2(DECK_SIZE);
  localparam logic [7:0] LAST      = 8'(DECK_SIZE - 1);
  localparam logic [7:0] FULL      = 8'(DECK_SIZE);

  dealer_state_t state, state_nxt;
  rank_t         deck [DECK_SIZE];
  rank_t         init_rank;
  logic [7:0]    idx, ptr, cand;
  logic [15:0]   lfsr;
  logic          pending, pend_nxt;
  logic          do_deal, do_swap, go_init, enter_ready;

  lfsr16 #(
    .POLY (16'hB400),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed      (seed),
    .state     (lfsr)
  );

  always_comb begin
    cand      = 8'(lfsr & {8'h0, fy_mask(idx)});
    state_nxt = state;
    pend_nxt  = pending;
    do_deal   = 1'b0;
    do_swap   = 1'b0;
    go_init   = 1'b0;
    unique case (state)
      S_INIT: begin
        if (deal_req) pend_nxt = 1'b1;
        if (idx == LAST) begin
`ifdef CARD_DEALER_TEST_DECK_EN
          state_nxt = S_READY;
`else
          state_nxt = S_SHUFFLE;
`endif
        end
      end
      S_SHUFFLE: begin
        if (deal_req) pend_nxt = 1'b1;
        if (cand <= idx) begin
          do_swap = 1'b1;
          if (idx == 8'd1) state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (shuffle_req) begin
          go_init   = 1'b1;
          state_nxt = S_INIT;
          pend_nxt  = pending | deal_req;
        end else if (pending || deal_req) begin
          if (cards_left == 8'd0) begin
            go_init   = 1'b1;
            state_nxt = S_INIT;
            pend_nxt  = 1'b1;
          end else begin
            do_deal  = 1'b1;
            pend_nxt = pending & deal_req;
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase
    enter_ready = (state_nxt == S_READY) && (state != S_READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      idx        <= 8'd0;
      init_rank  <= RANK_ACE;
      ptr        <= 8'd0;
      cards_left <= 8'd0;
      pending    <= 1'b0;
      deal_valid <= 1'b0;
      card_rank  <= 4'd0;
      card_value <= 4'd0;
    end else begin
      state      <= state_nxt;
      pending    <= pend_nxt;
      deal_valid <= do_deal;
      if (do_deal) begin
        card_rank  <= deck[ptr[IW-1:0]];
        card_value <= rank_to_value(deck[ptr[IW-1:0]]);
        ptr        <= ptr + 8'd1;
        cards_left <= cards_left - 8'd1;
      end
      if (go_init) begin
        idx        <= 8'd0;
        init_rank  <= RANK_ACE;
        cards_left <= 8'd0;
      end
      // idx parks on LAST so the shuffle starts from the top card
      if (state == S_INIT) begin
        idx       <= (idx == LAST) ? LAST : idx + 8'd1;
        init_rank <= (init_rank == RANK_KING) ? RANK_ACE : init_rank + 4'd1;
      end
      if (do_swap) idx <= idx - 8'd1;
      if (enter_ready) begin
        ptr        <= 8'd0;
        cards_left <= FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      deck[idx[IW-1:0]] <= init_rank;
    end else if (do_swap) begin
      deck[idx[IW-1:0]]  <= deck[cand[IW-1:0]];
      deck[cand[IW-1:0]] <= deck[idx[IW-1:0]];
    end
  end

  assign busy          = (state != S_READY);
  assign reshuffle_due = (state == S_READY) &&
                         (cards_left < 8'(RESHUFFLE_THRESH));

endmodule
